imem_program_loader: RTL and testbench
======================================

# imem_program_loader

Streams a program image into instruction memory over a byte-wide valid/ready link and holds the processor in reset until the image is complete and verified. It is the write-side counterpart of the instruction memory, which the processor only reads. It sits between the host/debug byte source and the instruction memory write port. Its `cpu_hold` output drives the processor's reset.

## Interface
- `ADDR_W`, 10: instruction memory word-address width.
- `DEPTH`, 1024: maximum loadable words; must be ≤ 2^ADDR_W.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse that begins a load.
- `rx_data` in 8: incoming image byte.
- `rx_valid` in 1: `rx_data` is valid.
- `rx_ready` out 1: loader accepts a byte this cycle.
- `imem_we` out 1: instruction memory write strobe, one-cycle pulse.
- `imem_addr` out ADDR_W: word address (word index, not byte address).
- `imem_wdata` out 32: assembled instruction word.
- `cpu_hold` out 1: high keeps the processor in reset.
- `busy` out 1: a load is in progress.
- `done` out 1: the last load succeeded.
- `error` out 1: the last load failed.
- `words_loaded` out ADDR_W+1: count of words written in the current or last load.

## Operation
- **Image format (big-endian):** CNT_HI, CNT_LO (16-bit word count N), then 4·N payload bytes, then CSUM.
  - CSUM is the XOR of all payload bytes only, not the header.
  - The first byte of each word goes to bits [31:24]; the fourth goes to [7:0].
- **Byte handshake:** a byte is consumed on a rising edge where `rx_valid && rx_ready`. `rx_valid` without `rx_ready` consumes nothing.
- **States:** IDLE, HDR_HI, HDR_LO, DATA, CSUM, DONE, ERROR.
  - IDLE, DONE, ERROR: `start` → HDR_HI. The cycle after `start`, clear `words_loaded`, the byte counter and the XOR accumulator, and deassert `done`/`error`.
  - HDR_HI: on a byte, latch CNT_HI → HDR_LO.
  - HDR_LO: on a byte, latch CNT_LO. Then:
    - N > DEPTH → ERROR, with no writes.
    - N == 0 → CSUM.
    - otherwise → DATA.
  - DATA: accumulate bytes and XOR each one into the accumulator.
    - On the 4th byte of a word, register the write; the word index increments after each write.
    - After word N-1's 4th byte → CSUM.
  - CSUM: on a byte, compare it with the accumulator. Match → DONE; mismatch → ERROR.
- **`start` handling:** `start` in HDR_HI, HDR_LO, DATA or CSUM is ignored.
- **`rx_ready`:** high in HDR_HI, HDR_LO, DATA and CSUM; low in IDLE, DONE and ERROR.
- **`busy`:** high in HDR_HI through CSUM.
- **`done` / `error`:** `done` is high only in DONE; `error` is high only in ERROR. Both are levels held until the next `start` or reset.
- **`cpu_hold`:**
  - high in every state except DONE;
  - a failed load leaves the processor held;
  - `start` from DONE re-asserts `cpu_hold` the next cycle.
- **`words_loaded`:** increments by one with each `imem_we` pulse. It saturates only by construction (N ≤ DEPTH).
- **Partial loads:** memory contents already written during a failed or reset-aborted load are not cleared.

## Timing
- **Reset values:**
  - state IDLE;
  - `rx_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0;
  - `cpu_hold`=1, `busy`=0, `done`=0, `error`=0, `words_loaded`=0.
- **Reset mid-load:** returns immediately to the reset values above.
- **Write latency:** if the 4th byte of word k is accepted at edge t, then `imem_we`=1, `imem_addr`=k and `imem_wdata`=word on the cycle after t. Exactly one cycle of write strobe per word.
- **`words_loaded` timing:** equals k+1 from the cycle after the `imem_we` pulse for word k.
- **Throughput:** one byte per cycle with `rx_valid` held high; there are no stall cycles.
- **Gaps:** gaps in `rx_valid` of any length are tolerated in any receiving state. There is no timeout.
- **CSUM → DONE:** CSUM byte accepted at edge t gives state DONE at t. Then `done`=1, `cpu_hold`=0 and `busy`=0 in the following cycle. The last `imem_we` pulse precedes or coincides with this, never follows it.
- **Minimum load time:** 3 + 4·N accepted bytes.

## Test plan
- **Reset:** `rst`=0 mid-DATA after 2 words → all outputs at reset values; `cpu_hold`=1, `words_loaded`=0, state IDLE; a new `start` loads normally.
- **Normal load:** `start`, bytes 00 02 | 24 08 00 05 | 00 00 00 0C | CSUM 0x25, `rx_valid` held high → two `imem_we` pulses:
  - addr 0 data 0x24080005;
  - addr 1 data 0x0000000C;
  - then `done`=1, `cpu_hold`=0, `words_loaded`=2.
- **Bad checksum:** same image with CSUM 0x00 → both writes occur, then `error`=1, `done`=0, `cpu_hold`=1.
- **Count limits:**
  - header 04 01 (N=1025 > DEPTH) → ERROR right after CNT_LO, with zero `imem_we` pulses;
  - header 00 00 followed by CSUM 00 → DONE with `words_loaded`=0.
- **Gaps and ignored start:** random `rx_valid` gaps of 0-5 cycles plus a `start` pulse mid-DATA → identical writes to the gap-free run; the `start` pulse has no effect.
- **Reload:** `start` from DONE → `cpu_hold` rises the next cycle and `done` clears; a second image overwrites addresses from 0 and `words_loaded` restarts from 0.

Source files
------------

// File: rtl/imem_program_loader.sv
// Streams a byte-wide program image (count, payload, XOR checksum) into instruction
// memory and keeps the processor held in reset until the image is complete and verified.
module imem_program_loader #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded,
  output logic [2:0]        dbg_state
);

  // Handshake: a byte moves on a rising edge where rx_valid && rx_ready; rx_ready is a
  // registered decode of the state and never depends on rx_valid.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HDR_HI = 3'd1,
    S_HDR_LO = 3'd2,
    S_DATA   = 3'd3,
    S_CSUM   = 3'd4,
    S_DONE   = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  localparam logic [16:0]   DEPTH_L = 17'(DEPTH);
  localparam logic [ADDR_W:0] ONE_W = 1;

  state_t              r_state;
  logic                r_rx_ready;
  logic                r_busy;
  logic                r_done;
  logic                r_error;
  logic                r_cpu_hold;
  logic                r_imem_we;
  logic [ADDR_W-1:0]   r_imem_addr;
  logic [31:0]         r_imem_wdata;
  logic [ADDR_W:0]     r_words_loaded;
  logic [ADDR_W:0]     r_word_idx;
  logic [ADDR_W:0]     r_cnt;
  logic [7:0]          r_cnt_hi;
  logic [1:0]          r_byte_idx;
  logic [23:0]         r_word_buf;
  logic [7:0]          r_csum;

  state_t              w_next_state;
  logic                w_accept;
  logic [15:0]         w_cnt_full;
  logic                w_cnt_too_big;
  logic                w_last_word;
  logic [31:0]         w_word;

  assign w_accept      = r_rx_ready && rx_valid;
  assign w_cnt_full    = {r_cnt_hi, rx_data};
  assign w_cnt_too_big = {1'b0, w_cnt_full} > DEPTH_L;
  // r_cnt is only consulted in DATA, where the count is known to be 1..DEPTH.
  assign w_last_word   = (r_word_idx == (r_cnt - ONE_W));
  assign w_word        = {r_word_buf, rx_data};

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) w_next_state = S_HDR_HI;
      end
      S_HDR_HI: begin
        if (w_accept) w_next_state = S_HDR_LO;
      end
      S_HDR_LO: begin
        if (w_accept) begin
          if (w_cnt_too_big)          w_next_state = S_ERROR;
          else if (w_cnt_full == 16'd0) w_next_state = S_CSUM;
          else                          w_next_state = S_DATA;
        end
      end
      S_DATA: begin
        if (w_accept && (r_byte_idx == 2'd3) && w_last_word) w_next_state = S_CSUM;
      end
      S_CSUM: begin
        if (w_accept) w_next_state = (rx_data == r_csum) ? S_DONE : S_ERROR;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= S_IDLE;
      r_rx_ready     <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_error        <= 1'b0;
      r_cpu_hold     <= 1'b1;
      r_imem_we      <= 1'b0;
      r_imem_addr    <= '0;
      r_imem_wdata   <= '0;
      r_words_loaded <= '0;
      r_word_idx     <= '0;
      r_cnt          <= '0;
      r_cnt_hi       <= '0;
      r_byte_idx     <= '0;
      r_word_buf     <= '0;
      r_csum         <= '0;
    end else begin
      r_state    <= w_next_state;
      r_rx_ready <= (w_next_state == S_HDR_HI) || (w_next_state == S_HDR_LO) ||
                    (w_next_state == S_DATA)   || (w_next_state == S_CSUM);
      r_busy     <= (w_next_state == S_HDR_HI) || (w_next_state == S_HDR_LO) ||
                    (w_next_state == S_DATA)   || (w_next_state == S_CSUM);
      r_done     <= (w_next_state == S_DONE);
      r_error    <= (w_next_state == S_ERROR);
      r_cpu_hold <= (w_next_state != S_DONE);
      r_imem_we  <= 1'b0;

      // The count trails the strobe by one cycle, so it reads k+1 after word k's pulse.
      if (r_imem_we) r_words_loaded <= r_words_loaded + ONE_W;

      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            r_words_loaded <= '0;
            r_word_idx     <= '0;
            r_byte_idx     <= '0;
            r_csum         <= '0;
          end
        end
        S_HDR_HI: begin
          if (w_accept) r_cnt_hi <= rx_data;
        end
        S_HDR_LO: begin
          if (w_accept) r_cnt <= w_cnt_full[ADDR_W:0];
        end
        S_DATA: begin
          if (w_accept) begin
            r_csum     <= r_csum ^ rx_data;
            r_byte_idx <= r_byte_idx + 2'd1;
            if (r_byte_idx == 2'd3) begin
              r_imem_we    <= 1'b1;
              r_imem_addr  <= r_word_idx[ADDR_W-1:0];
              r_imem_wdata <= w_word;
              r_word_idx   <= r_word_idx + ONE_W;
            end else begin
              r_word_buf <= {r_word_buf[15:0], rx_data};
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign rx_ready     = r_rx_ready;
  assign imem_we      = r_imem_we;
  assign imem_addr    = r_imem_addr;
  assign imem_wdata   = r_imem_wdata;
  assign cpu_hold     = r_cpu_hold;
  assign busy         = r_busy;
  assign done         = r_done;
  assign error        = r_error;
  assign words_loaded = r_words_loaded;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_imem_program_loader.sv
// Directed bench for imem_program_loader: drives images byte by byte at the falling
// edge and checks outputs, write timing and logged memory writes against hand values.
module tb_imem_program_loader;

  localparam int ADDR_W = 10;

  logic              clk;
  logic              rst;
  logic              start;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   words_loaded;
  logic [2:0]        dbg_state;

  int n_pass  = 0;
  int n_total = 0;

  int                we_count = 0;
  logic [ADDR_W-1:0] log_addr [0:63];
  logic [31:0]       log_data [0:63];

  imem_program_loader #(.ADDR_W(ADDR_W), .DEPTH(1024)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_hold(cpu_hold), .busy(busy), .done(done),
    .error(error), .words_loaded(words_loaded), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded limit");
    $fatal(1);
  end

  // write monitor: logs every strobe cycle
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      log_addr[we_count[5:0]] = imem_addr;
      log_data[we_count[5:0]] = imem_wdata;
      we_count = we_count + 1;
    end
  end

  // driver tasks (called at a falling edge, return at a falling edge)
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (rx_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (rx_ready !== 1'b1) begin
      n_total++;
      $display("FAIL send_timeout: rx_ready=%b required 1 for byte %h", rx_ready, b);
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    n_total++; if (rx_ready !== 1'b0) $display("FAIL rst_rx_ready: got %b want 0", rx_ready); else n_pass++;
    n_total++; if (imem_we !== 1'b0) $display("FAIL rst_we: got %b want 0", imem_we); else n_pass++;
    n_total++; if (imem_addr !== 10'd0) $display("FAIL rst_addr: got %0d want 0", imem_addr); else n_pass++;
    n_total++; if (imem_wdata !== 32'd0) $display("FAIL rst_wdata: got %h want 0", imem_wdata); else n_pass++;
    n_total++; if (cpu_hold !== 1'b1) $display("FAIL rst_cpu_hold: got %b want 1", cpu_hold); else n_pass++;
    n_total++; if ({busy, done, error} !== 3'b000) $display("FAIL rst_flags: got %b want 000", {busy, done, error}); else n_pass++;
    n_total++; if (words_loaded !== 11'd0) $display("FAIL rst_words: got %0d want 0", words_loaded); else n_pass++;
    n_total++; if (dbg_state !== 3'd0) $display("FAIL rst_state: got %0d want 0", dbg_state); else n_pass++;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_normal();
    int base;
    base = we_count;
    pulse_start();
    n_total++; if ({cpu_hold, busy} !== 2'b11) $display("FAIL normal_start_hold_busy: got %b want 11", {cpu_hold, busy}); else n_pass++;
    n_total++; if (dbg_state !== 3'd1) $display("FAIL normal_start_state: got %0d want 1", dbg_state); else n_pass++;
    send_byte(8'h00); send_byte(8'h02);
    n_total++; if (dbg_state !== 3'd3) $display("FAIL normal_hdr_state: got %0d want 3", dbg_state); else n_pass++;
    send_byte(8'h24); send_byte(8'h08); send_byte(8'h00); send_byte(8'h05);
    n_total++; if (imem_we !== 1'b1) $display("FAIL normal_we0: got %b want 1", imem_we); else n_pass++;
    n_total++; if (imem_addr !== 10'd0) $display("FAIL normal_addr0: got %0d want 0", imem_addr); else n_pass++;
    n_total++; if (imem_wdata !== 32'h24080005) $display("FAIL normal_data0: got %h want 24080005", imem_wdata); else n_pass++;
    n_total++; if (words_loaded !== 11'd0) $display("FAIL normal_words_pre: got %0d want 0", words_loaded); else n_pass++;
    send_byte(8'h00);
    n_total++; if (imem_we !== 1'b0) $display("FAIL normal_we_single: got %b want 0", imem_we); else n_pass++;
    n_total++; if (words_loaded !== 11'd1) $display("FAIL normal_words1: got %0d want 1", words_loaded); else n_pass++;
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h0C);
    n_total++; if (imem_we !== 1'b1) $display("FAIL normal_we1: got %b want 1", imem_we); else n_pass++;
    n_total++; if (imem_addr !== 10'd1) $display("FAIL normal_addr1: got %0d want 1", imem_addr); else n_pass++;
    n_total++; if (imem_wdata !== 32'h0000000C) $display("FAIL normal_data1: got %h want 0000000c", imem_wdata); else n_pass++;
    send_byte(8'h25);
    n_total++; if ({done, error, cpu_hold, busy} !== 4'b1000) $display("FAIL normal_done_flags: got %b want 1000", {done, error, cpu_hold, busy}); else n_pass++;
    n_total++; if (words_loaded !== 11'd2) $display("FAIL normal_words2: got %0d want 2", words_loaded); else n_pass++;
    n_total++; if (rx_ready !== 1'b0) $display("FAIL normal_ready_done: got %b want 0", rx_ready); else n_pass++;
    n_total++; if (dbg_state !== 3'd5) $display("FAIL normal_state_done: got %0d want 5", dbg_state); else n_pass++;
    @(negedge clk);
    n_total++; if (we_count - base !== 2) $display("FAIL normal_we_count: got %0d want 2", we_count - base); else n_pass++;
  endtask

  task automatic test_bad_csum();
    int base;
    base = we_count;
    pulse_start();
    n_total++; if ({done, cpu_hold} !== 2'b01) $display("FAIL bad_start_flags: got %b want 01", {done, cpu_hold}); else n_pass++;
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h24); send_byte(8'h08); send_byte(8'h00); send_byte(8'h05);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h0C);
    send_byte(8'h00);
    @(negedge clk);
    n_total++; if ({error, done, cpu_hold} !== 3'b101) $display("FAIL bad_flags: got %b want 101", {error, done, cpu_hold}); else n_pass++;
    n_total++; if (dbg_state !== 3'd6) $display("FAIL bad_state: got %0d want 6", dbg_state); else n_pass++;
    n_total++; if (we_count - base !== 2) $display("FAIL bad_we_count: got %0d want 2", we_count - base); else n_pass++;
    n_total++; if (log_data[(base + 1) % 64] !== 32'h0000000C) $display("FAIL bad_data1: got %h want 0000000c", log_data[(base + 1) % 64]); else n_pass++;
  endtask

  task automatic test_count_limits();
    int base;
    base = we_count;
    pulse_start();
    send_byte(8'h04); send_byte(8'h01);
    n_total++; if (dbg_state !== 3'd6) $display("FAIL big_state: got %0d want 6", dbg_state); else n_pass++;
    n_total++; if ({error, rx_ready, busy} !== 3'b100) $display("FAIL big_flags: got %b want 100", {error, rx_ready, busy}); else n_pass++;
    repeat (3) @(negedge clk);
    n_total++; if (we_count - base !== 0) $display("FAIL big_no_writes: got %0d want 0", we_count - base); else n_pass++;
    pulse_start();
    send_byte(8'h00); send_byte(8'h00);
    n_total++; if (dbg_state !== 3'd4) $display("FAIL zero_state_csum: got %0d want 4", dbg_state); else n_pass++;
    send_byte(8'h00);
    n_total++; if ({done, cpu_hold} !== 2'b10) $display("FAIL zero_done: got %b want 10", {done, cpu_hold}); else n_pass++;
    n_total++; if (words_loaded !== 11'd0) $display("FAIL zero_words: got %0d want 0", words_loaded); else n_pass++;
  endtask

  task automatic test_gaps_ignored_start();
    int base;
    logic [7:0] img [0:10];
    logic [31:0] exp_q [$];
    logic [31:0] exp_w;
    img = '{8'h00, 8'h02, 8'h24, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h0C, 8'h25};
    exp_q = '{32'h24080005, 32'h0000000C};
    base = we_count;
    pulse_start();
    for (int i = 0; i < 11; i++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      if (i == 6) begin
        pulse_start();
        n_total++; if ({dbg_state, busy} !== {3'd3, 1'b1}) $display("FAIL gap_start_ignored: got state %0d busy %b want 3 1", dbg_state, busy); else n_pass++;
        n_total++; if (words_loaded !== 11'd1) $display("FAIL gap_words_kept: got %0d want 1", words_loaded); else n_pass++;
      end
      send_byte(img[i]);
    end
    @(negedge clk);
    n_total++; if ({done, cpu_hold} !== 2'b10) $display("FAIL gap_done: got %b want 10", {done, cpu_hold}); else n_pass++;
    n_total++; if (we_count - base !== 2) $display("FAIL gap_we_count: got %0d want 2", we_count - base); else n_pass++;
    for (int k = 0; k < 2; k++) begin
      exp_w = exp_q.pop_front();
      n_total++; if (log_data[(base + k) % 64] !== exp_w) $display("FAIL gap_data%0d: got %h want %h", k, log_data[(base + k) % 64], exp_w); else n_pass++;
      n_total++; if (log_addr[(base + k) % 64] !== 10'(k)) $display("FAIL gap_addr%0d: got %0d want %0d", k, log_addr[(base + k) % 64], k); else n_pass++;
    end
  endtask

  task automatic test_reload();
    pulse_start();
    n_total++; if ({cpu_hold, done, busy} !== 3'b101) $display("FAIL reload_flags: got %b want 101", {cpu_hold, done, busy}); else n_pass++;
    n_total++; if (words_loaded !== 11'd0) $display("FAIL reload_words_clr: got %0d want 0", words_loaded); else n_pass++;
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'hCA); send_byte(8'hFE); send_byte(8'hF0); send_byte(8'h0D);
    n_total++; if ({imem_we, imem_addr} !== {1'b1, 10'd0}) $display("FAIL reload_we_addr: got %b %0d want 1 0", imem_we, imem_addr); else n_pass++;
    n_total++; if (imem_wdata !== 32'hCAFEF00D) $display("FAIL reload_data: got %h want cafef00d", imem_wdata); else n_pass++;
    send_byte(8'hC9);
    n_total++; if ({done, cpu_hold} !== 2'b10) $display("FAIL reload_done: got %b want 10", {done, cpu_hold}); else n_pass++;
    n_total++; if (words_loaded !== 11'd1) $display("FAIL reload_words: got %0d want 1", words_loaded); else n_pass++;
  endtask

  task automatic test_reset_midload();
    pulse_start();
    send_byte(8'h00); send_byte(8'h03);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
    n_total++; if ({imem_we, words_loaded} !== {1'b1, 11'd1}) $display("FAIL mid_pre_reset: got we %b words %0d want 1 1", imem_we, words_loaded); else n_pass++;
    rst = 1'b0;
    #1;
    n_total++; if ({rx_ready, imem_we, busy, done, error} !== 5'b00000) $display("FAIL mid_rst_flags: got %b want 00000", {rx_ready, imem_we, busy, done, error}); else n_pass++;
    n_total++; if ({imem_addr, imem_wdata} !== 42'd0) $display("FAIL mid_rst_addr_data: got %0d %h want 0 0", imem_addr, imem_wdata); else n_pass++;
    n_total++; if ({cpu_hold, words_loaded} !== {1'b1, 11'd0}) $display("FAIL mid_rst_hold_words: got %b %0d want 1 0", cpu_hold, words_loaded); else n_pass++;
    n_total++; if (dbg_state !== 3'd0) $display("FAIL mid_rst_state: got %0d want 0", dbg_state); else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    test_normal();
  endtask

  initial begin
    test_reset();
    test_normal();
    test_bad_csum();
    test_count_limits();
    test_gaps_ignored_start();
    test_reload();
    test_reset_midload();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
